// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode constants and front-end defaults
// Shared by the fetch-stage PC prediction logic.
package y86_pkg;

  localparam int ADDR_W_DEFAULT = 64;
  localparam int HIST_LEN       = 3;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Instructions whose predicted successor is their constant field.
  function automatic logic is_valc_target(input logic [3:0] icode);
    return (icode == IJXX) || (icode == ICALL);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with pointer restore
// Restore/clear form a base state this cycle; push/pop act on top of it.
module ras_stack #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic                         i_restore,
  input  logic [$clog2(DEPTH)-1:0]     i_restore_top,
  input  logic [$clog2(DEPTH+1)-1:0]   i_restore_cnt,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [ADDR_W-1:0]            i_push_data,
  output logic [ADDR_W-1:0]            o_top_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_base_cnt,
  output logic [$clog2(DEPTH)-1:0]     o_nxt_top,
  output logic [$clog2(DEPTH+1)-1:0]   o_nxt_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
  output logic                         o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_overflow;

  logic [PTR_W-1:0]  w_base_top;
  logic [CNT_W-1:0]  w_base_cnt;
  logic [PTR_W-1:0]  w_nxt_top;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic              w_ovf_set;

  always_comb begin
    w_base_top = r_top;
    w_base_cnt = r_cnt;
    if (i_restore) begin
      w_base_top = i_restore_top;
      w_base_cnt = i_restore_cnt;
    end
    if (i_clear) begin
      w_base_cnt = '0;
    end

    w_nxt_top = w_base_top;
    w_nxt_cnt = w_base_cnt;
    w_ovf_set = 1'b0;
    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    if (i_push) begin
      w_nxt_top = w_base_top + PTR_ONE;
      if (w_base_cnt == CNT_FULL) begin
        w_ovf_set = 1'b1;
      end else begin
        w_nxt_cnt = w_base_cnt + CNT_ONE;
      end
    end else if (i_pop && (w_base_cnt != '0)) begin
      w_nxt_top = w_base_top - PTR_ONE;
      w_nxt_cnt = w_base_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (i_en) begin
      r_top <= w_nxt_top;
      r_cnt <= w_nxt_cnt;
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_en && i_push) begin
      r_mem[w_nxt_top] <= i_push_data;
    end
  end

  assign o_top_data = r_mem[w_base_top];
  assign o_base_cnt = w_base_cnt;
  assign o_nxt_top  = w_nxt_top;
  assign o_nxt_cnt  = w_nxt_cnt;
  assign o_cnt      = r_cnt;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - fetch PC select and next-PC prediction
// Optional return-address stack enabled by defining PC_PREDICT_RAS_EN.
module pc_predict_unit
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEFAULT,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             f_valid,
  input  logic [3:0]                       f_icode,
  input  logic [ADDR_W-1:0]                f_valC,
  input  logic [ADDR_W-1:0]                f_valP,
  input  logic [3:0]                       m_icode,
  input  logic                             m_cnd,
  input  logic [ADDR_W-1:0]                m_valA,
  input  logic [3:0]                       w_icode,
  input  logic [ADDR_W-1:0]                w_valM,
  input  logic [ADDR_W-1:0]                w_predpc,
  output logic [ADDR_W-1:0]                f_pc,
  output logic [ADDR_W-1:0]                pred_pc,
  output logic                             ret_redirect,
  output logic                             jmp_redirect,
  output logic                             ret_pending,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow
);

  logic [ADDR_W-1:0] r_pred;
  logic [ADDR_W-1:0] w_pred_nxt;
  logic [ADDR_W-1:0] w_ret_target;
  logic              w_jmp;
  logic              w_ret;
  logic              w_fetch;

  // jXX is always predicted taken, so only a not-taken jump in M redirects.
  assign w_jmp   = !rst && (m_icode == IJXX) && !m_cnd;
  assign w_fetch = !stall && f_valid;

`ifdef PC_PREDICT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  logic [ADDR_W-1:0] w_ras_top;
  logic [CNT_W-1:0]  w_ras_base_cnt;
  logic [PTR_W-1:0]  w_ras_nxt_top;
  logic [CNT_W-1:0]  w_ras_nxt_cnt;
  logic [CNT_W-1:0]  w_ras_cnt;
  logic              w_ras_ovf;
  logic [PTR_W-1:0]  r_hist_top [HIST_LEN];
  logic [CNT_W-1:0]  r_hist_cnt [HIST_LEN];

  // A correctly predicted ret carries its RAS target as w_predpc.
  assign w_ret = !rst && (w_icode == IRET) && (w_valM != w_predpc);

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk           (clk),
    .rst           (rst),
    .i_en          (!stall),
    .i_restore     (w_jmp),
    .i_restore_top (r_hist_top[HIST_LEN-1]),
    .i_restore_cnt (r_hist_cnt[HIST_LEN-1]),
    .i_clear       (w_ret),
    .i_push        (w_fetch && (f_icode == ICALL)),
    .i_pop         (w_fetch && (f_icode == IRET)),
    .i_push_data   (f_valP),
    .o_top_data    (w_ras_top),
    .o_base_cnt    (w_ras_base_cnt),
    .o_nxt_top     (w_ras_nxt_top),
    .o_nxt_cnt     (w_ras_nxt_cnt),
    .o_cnt         (w_ras_cnt),
    .o_overflow    (w_ras_ovf)
  );

  // The oldest entry is the post-op state from when the jump now in M was fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HIST_LEN; i++) begin
        r_hist_top[i] <= '0;
        r_hist_cnt[i] <= '0;
      end
    end else if (!stall) begin
      r_hist_top[0] <= w_ras_nxt_top;
      r_hist_cnt[0] <= w_ras_nxt_cnt;
      for (int i = 1; i < HIST_LEN; i++) begin
        r_hist_top[i] <= r_hist_top[i-1];
        r_hist_cnt[i] <= r_hist_cnt[i-1];
      end
    end
  end

  assign w_ret_target = (w_ras_base_cnt != '0) ? w_ras_top : f_valP;
  assign ras_count    = w_ras_cnt;
  assign ras_overflow = w_ras_ovf;
  assign ret_pending  = 1'b0;
`else
  logic r_ret_pending;
  logic w_unused_predpc;

  // Without a RAS every ret is resolved in W and the front end bubbles meanwhile.
  assign w_ret = !rst && (w_icode == IRET);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_pending <= 1'b0;
    end else if (!stall) begin
      if (f_valid && (f_icode == IRET)) begin
        r_ret_pending <= 1'b1;
      end else if (w_icode == IRET) begin
        r_ret_pending <= 1'b0;
      end
    end
  end

  assign w_unused_predpc = ^w_predpc;
  assign w_ret_target    = f_valP;
  assign ras_count       = '0;
  assign ras_overflow    = 1'b0;
  assign ret_pending     = r_ret_pending;
`endif

  assign f_pc = rst   ? RESET_PC :
                w_ret ? w_valM   :
                w_jmp ? m_valA   : r_pred;

  always_comb begin
    w_pred_nxt = f_pc;
    if (f_valid) begin
      if (is_valc_target(f_icode)) begin
        w_pred_nxt = f_valC;
      end else if (f_icode == IRET) begin
        w_pred_nxt = w_ret_target;
      end else begin
        w_pred_nxt = f_valP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred <= RESET_PC;
    end else if (!stall) begin
      r_pred <= w_pred_nxt;
    end
  end

  assign pred_pc      = r_pred;
  assign ret_redirect = w_ret;
  assign jmp_redirect = w_jmp;

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb/tb_pc_predict_unit.sv - randomized and directed bench for pc_predict_unit
// Follows PC_PREDICT_RAS_EN the same way the design does.
module tb_pc_predict_unit;

  localparam int RAS_DEPTH = 8;
`ifdef PC_PREDICT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, f_valid, m_cnd;
  logic [3:0]  f_icode, m_icode, w_icode;
  logic [63:0] f_valC, f_valP, m_valA, w_valM, w_predpc;
  logic [63:0] f_pc, pred_pc;
  logic        ret_redirect, jmp_redirect, ret_pending, ras_overflow;
  logic [3:0]  ras_count;

  int n_cmp = 0;
  int n_bad = 0;

  pc_predict_unit #(
    .ADDR_W    (64),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (64'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .f_valid      (f_valid),
    .f_icode      (f_icode),
    .f_valC       (f_valC),
    .f_valP       (f_valP),
    .m_icode      (m_icode),
    .m_cnd        (m_cnd),
    .m_valA       (m_valA),
    .w_icode      (w_icode),
    .w_valM       (w_valM),
    .w_predpc     (w_predpc),
    .f_pc         (f_pc),
    .pred_pc      (pred_pc),
    .ret_redirect (ret_redirect),
    .jmp_redirect (jmp_redirect),
    .ret_pending  (ret_pending),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: architectural stack of return addresses plus snapshots.
  logic [63:0] md_pred;
  logic [63:0] md_mem [RAS_DEPTH];
  int          md_top, md_cnt;
  bit          md_ovf, md_rp;
  int          md_ht [3];
  int          md_hc [3];
  bit          ex_ret, ex_jmp;
  logic [63:0] ex_fpc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    md_pred = 64'h0;
    md_top  = 0;
    md_cnt  = 0;
    md_ovf  = 0;
    md_rp   = 0;
    for (int i = 0; i < 3; i++) begin
      md_ht[i] = 0;
      md_hc[i] = 0;
    end
  endtask

  task automatic model_comb();
    ex_jmp = !rst && (m_icode == 4'd7) && !m_cnd;
    ex_ret = !rst && (w_icode == 4'd9) && (!RAS_ON || (w_valM != w_predpc));
    ex_fpc = rst ? 64'h0 : ex_ret ? w_valM : ex_jmp ? m_valA : md_pred;
  endtask

  task automatic model_seq();
    int t, c;
    if (rst) begin
      model_reset();
    end else if (!stall) begin
      t = md_top;
      c = md_cnt;
      if (ex_jmp) begin
        t = md_ht[2];
        c = md_hc[2];
      end
      if (ex_ret) c = 0;
      if (f_valid) begin
        case (f_icode)
          4'd7, 4'd8: md_pred = f_valC;
          4'd9:       md_pred = (RAS_ON && c > 0) ? md_mem[t] : f_valP;
          default:    md_pred = f_valP;
        endcase
      end else begin
        md_pred = ex_fpc;
      end
      if (RAS_ON && f_valid && f_icode == 4'd8) begin
        t = (t + 1) % RAS_DEPTH;
        md_mem[t] = f_valP;
        if (c == RAS_DEPTH) md_ovf = 1;
        else c = c + 1;
      end else if (RAS_ON && f_valid && f_icode == 4'd9 && c > 0) begin
        t = (t + RAS_DEPTH - 1) % RAS_DEPTH;
        c = c - 1;
      end
      md_ht[2] = md_ht[1]; md_hc[2] = md_hc[1];
      md_ht[1] = md_ht[0]; md_hc[1] = md_hc[0];
      md_ht[0] = t;        md_hc[0] = c;
      md_top = t;
      md_cnt = c;
      if (!RAS_ON) begin
        if (f_valid && f_icode == 4'd9) md_rp = 1;
        else if (w_icode == 4'd9) md_rp = 0;
      end
    end
  endtask

  // Entered just after a rising edge with inputs already driven.
  task automatic step();
    #1;
    model_comb();
    check_eq("f_pc", f_pc, ex_fpc);
    check_eq("ret_redirect", {63'h0, ret_redirect}, {63'h0, ex_ret});
    check_eq("jmp_redirect", {63'h0, jmp_redirect}, {63'h0, ex_jmp});
    @(posedge clk);
    model_seq();
    #1;
    check_eq("pred_pc", pred_pc, md_pred);
    check_eq("ras_count", {60'h0, ras_count}, 64'(md_cnt));
    check_eq("ras_overflow", {63'h0, ras_overflow}, {63'h0, md_ovf});
    check_eq("ret_pending", {63'h0, ret_pending}, {63'h0, md_rp});
  endtask

  task automatic idle();
    rst = 0; stall = 0; f_valid = 0; f_icode = 4'd1; f_valC = 0; f_valP = 0;
    m_icode = 4'd1; m_cnd = 1; m_valA = 0; w_icode = 4'd1; w_valM = 0; w_predpc = 0;
  endtask

  task automatic fetch(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp);
    idle();
    f_valid = 1; f_icode = icode; f_valC = valc; f_valP = valp;
    step();
  endtask

  initial begin
    int r;
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    // Reset for two cycles
    rst = 1; step();
    rst = 1; step();
    idle();
    #1;
    check_eq("rst_pred_pc", pred_pc, 64'h0);
    check_eq("rst_f_pc", f_pc, 64'h0);
    check_eq("rst_ras_count", {60'h0, ras_count}, 64'h0);
    check_eq("rst_ret_pending", {63'h0, ret_pending}, 64'h0);

    fetch(4'd3, 64'h0, 64'hA);
    check_eq("irmovq_pred", pred_pc, 64'hA);
    fetch(4'd8, 64'h200, 64'h109);
    check_eq("call_pred", pred_pc, 64'h200);
    fetch(4'd7, 64'h40, 64'h19);
    check_eq("jxx_pred", pred_pc, 64'h40);
    fetch(4'd8, 64'h300, 64'h45);
    idle(); step();
    idle(); m_icode = 4'd7; m_cnd = 0; m_valA = 64'h19;
    #1;
    check_eq("jmp_f_pc", f_pc, 64'h19);
    check_eq("jmp_redirect_dir", {63'h0, jmp_redirect}, 64'h1);
    step();
    check_eq("jmp_restore_cnt", {60'h0, ras_count}, RAS_ON ? 64'h1 : 64'h0);
    check_eq("jmp_pred", pred_pc, 64'h19);

    fetch(4'd9, 64'h0, 64'h77);
    check_eq("ret_pred", pred_pc, RAS_ON ? 64'h109 : 64'h77);
    check_eq("ret_pending_set", {63'h0, ret_pending}, RAS_ON ? 64'h0 : 64'h1);
    idle(); w_icode = 4'd9; w_predpc = 64'h109; w_valM = RAS_ON ? 64'h109 : 64'h55;
    #1;
    check_eq("wret_f_pc", f_pc, RAS_ON ? 64'h109 : 64'h55);
    check_eq("wret_redirect", {63'h0, ret_redirect}, RAS_ON ? 64'h0 : 64'h1);
    step();
    check_eq("ret_pending_clr", {63'h0, ret_pending}, 64'h0);

    // Overflow then drain past empty
    idle(); rst = 1; step();
    for (int i = 0; i < 9; i++) fetch(4'd8, 64'h500, 64'h1000 + 64'(i) * 64'h10);
    check_eq("ovf_count", {60'h0, ras_count}, RAS_ON ? 64'h8 : 64'h0);
    check_eq("ovf_flag", {63'h0, ras_overflow}, RAS_ON ? 64'h1 : 64'h0);
    for (int j = 0; j < 9; j++) begin
      fetch(4'd9, 64'h0, 64'h2000 + 64'(j));
      check_eq("drain_pred", pred_pc,
               (RAS_ON && j < 8) ? 64'h1000 + 64'(8 - j) * 64'h10 : 64'h2000 + 64'(j));
    end
    fetch(4'd8, 64'h600, 64'h3000);
    check_eq("pre_clear_cnt", {60'h0, ras_count}, RAS_ON ? 64'h1 : 64'h0);
    idle(); w_icode = 4'd9; w_valM = 64'h1234; w_predpc = 64'h2008;
    #1;
    check_eq("ovf_ret_redirect", {63'h0, ret_redirect}, 64'h1);
    check_eq("ovf_ret_f_pc", f_pc, 64'h1234);
    step();
    check_eq("clear_cnt", {60'h0, ras_count}, 64'h0);

    // Randomized traffic, checked every cycle against the model
    for (int k = 0; k < 3000; k++) begin
      idle();
      rst     = ($urandom_range(0, 199) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      f_valid = ($urandom_range(0, 7) != 0);
      r = int'($urandom_range(0, 9));
      f_icode = (r < 3) ? 4'd8 : (r < 6) ? 4'd9 : (r < 7) ? 4'd7 : 4'($urandom_range(0, 11));
      f_valC  = {$urandom, $urandom};
      f_valP  = {$urandom, $urandom};
      m_icode = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 11));
      m_cnd   = 1'($urandom_range(0, 1));
      m_valA  = {$urandom, $urandom};
      w_icode = ($urandom_range(0, 6) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
      w_predpc = 64'($urandom_range(1, 4)) << 4;
      w_valM   = 64'($urandom_range(1, 4)) << 4;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
